switch_phase_sequencer: RTL and testbench

Controller that sequences the analog switch drive on the PMOD outputs (JC/JD). It generates two complementary, non-overlapping switch phases with a programmable half-period and dead time. It supports continuous or fixed-count burst operation under a start/stop handshake. At its default configuration it produces the 2.083 kHz, 100 MHz-derived switching waveform (48000-cycle period), with dead time inserted so both switches are never closed at once.

---
 rtl/switch_phase_sequencer_if.sv | 35 +++
 rtl/switch_phase_sequencer.sv | 159 +++++++++++++++
 tb/tb_switch_phase_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_phase_sequencer_if.sv
// Bundles the control inputs and status outputs of the switch phase sequencer.
//
// start and stop are level-sampled on every rising clk edge; there is no
// valid/ready pairing. start is accepted only while busy=0 (and stop=0), and
// stop is honoured only while a run is in progress (not while STOPPING).
// The config fields are captured in the same edge that accepts start and
// are ignored at all other times.
interface switch_phase_sequencer_if #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 16
);
  logic               start;
  logic               stop;
  logic [CNT_W-1:0]   half_period;
  logic [CNT_W-1:0]   dead_time;
  logic [BURST_W-1:0] burst_len;
  logic               phase_a;
  logic               phase_b;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic [BURST_W-1:0] cycle_cnt;

  // Controller / bench side: drives requests and config, observes status.
  modport master (
    output start, stop, half_period, dead_time, burst_len,
    input  phase_a, phase_b, busy, done, cfg_err, cycle_cnt
  );

  // Sequencer side.
  modport slave (
    input  start, stop, half_period, dead_time, burst_len,
    output phase_a, phase_b, busy, done, cfg_err, cycle_cnt
  );
endinterface

// File: rtl/switch_phase_sequencer.sv
// Two-phase non-overlapping switch driver with programmable half period,
// dead time and burst length. All outputs are registered and decoded from
// the next state so they change together with the state register.
module switch_phase_sequencer #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  switch_phase_sequencer_if.slave bus,
  output logic [2:0]              state_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PH_A     = 3'd1;
  localparam logic [2:0] DEAD_AB  = 3'd2;
  localparam logic [2:0] PH_B     = 3'd3;
  localparam logic [2:0] DEAD_BA  = 3'd4;
  localparam logic [2:0] STOPPING = 3'd5;

  localparam logic [CNT_W-1:0]   ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] ONE_B = {{(BURST_W-1){1'b0}}, 1'b1};

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hp_q, hp_d;
  logic [CNT_W-1:0]   dt_q, dt_d;
  logic [BURST_W-1:0] bl_q, bl_d;
  logic [BURST_W-1:0] cycle_q, cycle_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               pa_q, pa_d;
  logic               pb_q, pb_d;
  logic               busy_q, busy_d;

  logic [CNT_W-1:0]   dwell;
  logic               last;
  logic               dt_zero;
  logic [BURST_W-1:0] cycle_inc;
  logic               burst_end;

  // Dwell of the current state, end-of-dwell detect and period bookkeeping.
  always_comb begin
    dwell     = ((state_q == PH_A) || (state_q == PH_B)) ? (hp_q - dt_q) : dt_q;
    last      = (cnt_q == (dwell - ONE_C));
    dt_zero   = (dt_q == '0);
    cycle_inc = cycle_q + ONE_B;
    burst_end = (bl_q != '0) && (cycle_inc == bl_q);
  end

  // Next-state logic; a stop request pre-empts any normal phase transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + ONE_C;
    hp_d    = hp_q;
    dt_d    = dt_q;
    bl_d    = bl_q;
    cycle_d = cycle_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          if (bus.half_period > bus.dead_time) begin
            hp_d    = bus.half_period;
            dt_d    = bus.dead_time;
            bl_d    = bus.burst_len;
            cycle_d = '0;
            state_d = PH_A;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PH_A, DEAD_AB, PH_B, DEAD_BA: begin
        if (bus.stop) begin
          if (dt_zero) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = STOPPING;
          end
        end else if (last) begin
          case (state_q)
            PH_A:    state_d = dt_zero ? PH_B : DEAD_AB;
            DEAD_AB: state_d = PH_B;
            PH_B:    state_d = dt_zero ? PH_A : DEAD_BA;
            default: state_d = PH_A;
          endcase
          // A full period closes at the end of B's trailing dead band
          // (or of PH_B itself when there is no dead band).
          if ((state_q == DEAD_BA) || ((state_q == PH_B) && dt_zero)) begin
            cycle_d = cycle_inc;
            if (burst_end) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      STOPPING: begin
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Every state entry restarts the dwell counter.
    if ((state_d != state_q) || (state_q == IDLE)) begin
      cnt_d = '0;
    end
  end

  // Outputs decoded from the next state so they are registered with it.
  always_comb begin
    pa_d   = (state_d == PH_A);
    pb_d   = (state_d == PH_B);
    busy_d = (state_d != IDLE);
  end

  // State, counters, latched config and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hp_q    <= '0;
      dt_q    <= '0;
      bl_q    <= '0;
      cycle_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pa_q    <= 1'b0;
      pb_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      dt_q    <= dt_d;
      bl_q    <= bl_d;
      cycle_q <= cycle_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.phase_a   = pa_q;
  assign bus.phase_b   = pb_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = err_q;
  assign bus.cycle_cnt = cycle_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_switch_phase_sequencer.sv
// Bench for switch_phase_sequencer: directed scenarios with literal
// expectations, then a randomized phase, all shadowed by a time-based model.
module tb_switch_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] state_dbg;

  switch_phase_sequencer_if bus ();

  switch_phase_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .state_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int rel = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (rel cycle %0d, t=%0t)", name, act, exp, rel, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 running, 2 draining after stop.
  // m_t is the position inside the current 2*half_period period, where
  // position 0 is the first cycle phase_a is high.
  int          m_mode, m_t, m_left, m_hp, m_dt;
  logic [15:0] m_bl, m_cnt;
  logic        m_done, m_err;

  always @(posedge clk) begin : model_step
    int          mode, t, left, hp, dt;
    logic [15:0] bl, cnt;
    logic        dn, er;
    mode = m_mode; t = m_t; left = m_left; hp = m_hp; dt = m_dt;
    bl = m_bl; cnt = m_cnt; dn = 1'b0; er = 1'b0;
    if (!rst_n) begin
      mode = 0; t = 0; left = 0; hp = 0; dt = 0; bl = '0; cnt = '0;
    end else begin
      case (mode)
        0: if (bus.start && !bus.stop) begin
          if (bus.half_period > bus.dead_time) begin
            hp = int'(bus.half_period); dt = int'(bus.dead_time); bl = bus.burst_len;
            cnt = '0; t = 0; mode = 1;
          end else begin
            er = 1'b1;
          end
        end
        1: if (bus.stop) begin
          if (dt == 0) begin mode = 0; dn = 1'b1; end
          else begin mode = 2; left = dt; end
        end else begin
          t = (t + 1) % (2 * hp);
          if (t == 0) begin
            cnt = cnt + 16'd1;
            if (bl != 0 && cnt == bl) begin mode = 0; dn = 1'b1; end
          end
        end
        default: begin
          left = left - 1;
          if (left == 0) begin mode = 0; dn = 1'b1; end
        end
      endcase
    end
    m_mode <= mode; m_t <= t; m_left <= left; m_hp <= hp; m_dt <= dt;
    m_bl <= bl; m_cnt <= cnt; m_done <= dn; m_err <= er;
  end

  // ---------------- compare process (every cycle, on the falling edge) ----------------
  always @(negedge clk) begin : compare
    logic ea, eb;
    if (chk_en) begin
      ea = 1'b0; eb = 1'b0;
      if (m_mode == 1) begin
        ea = (m_t < m_hp - m_dt);
        eb = (m_t >= m_hp) && (m_t < 2 * m_hp - m_dt);
      end
      check("m_phase_a", bus.phase_a, ea);
      check("m_phase_b", bus.phase_b, eb);
      check("m_busy", bus.busy, m_mode != 0);
      check("m_done", bus.done, m_done);
      check("m_cfg_err", bus.cfg_err, m_err);
      check("m_cycle_cnt", bus.cycle_cnt, m_cnt);
      check("no_overlap", bus.phase_a & bus.phase_b, 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic go(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rel++;
    end
  endtask

  task automatic go_to(input int r);
    go(r - rel);
  endtask

  // Start is high in relative cycle 0; returns in relative cycle 1.
  task automatic launch(input int hp, input int dt, input int bl);
    bus.half_period = 16'(hp);
    bus.dead_time   = 16'(dt);
    bus.burst_len   = 16'(bl);
    bus.start       = 1'b1;
    rel = 0;
    go(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy && k < 200) begin
      go(1);
      k++;
    end
    check("wait_idle_timeout", bus.busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 1'b0; bus.stop = 1'b0;
    bus.half_period = '0; bus.dead_time = '0; bus.burst_len = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset state
    check("rst_phase_a", bus.phase_a, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_cycle_cnt", bus.cycle_cnt, 16'd0);
    go(2);

    // Burst: hp=10 dt=2 bl=3; config changes during the run must be ignored
    launch(10, 2, 3);
    bus.half_period = 16'd3; bus.dead_time = 16'd0; bus.burst_len = 16'd1;
    check("burst_pa_c1", bus.phase_a, 1'b1);
    check("burst_busy_c1", bus.busy, 1'b1);
    go_to(8);  check("burst_pa_c8", bus.phase_a, 1'b1);
    go_to(9);  check("burst_pa_c9", bus.phase_a, 1'b0);
    check("burst_pb_c9", bus.phase_b, 1'b0);
    go_to(11); check("burst_pb_c11", bus.phase_b, 1'b1);
    go_to(18); check("burst_pb_c18", bus.phase_b, 1'b1);
    go_to(19); check("burst_pb_c19", bus.phase_b, 1'b0);
    go_to(21); check("burst_pa_c21", bus.phase_a, 1'b1);
    check("burst_cnt_c21", bus.cycle_cnt, 16'd1);
    go_to(60); check("burst_busy_c60", bus.busy, 1'b1);
    check("burst_cnt_c60", bus.cycle_cnt, 16'd2);
    go_to(61); check("burst_done_c61", bus.done, 1'b1);
    check("burst_busy_c61", bus.busy, 1'b0);
    check("burst_cnt_c61", bus.cycle_cnt, 16'd3);
    go_to(62); check("burst_done_c62", bus.done, 1'b0);

    // Stop mid-phase: hp=10 dt=2 continuous, stop in cycle 13
    launch(10, 2, 0);
    go_to(13); check("stop_pb_c13", bus.phase_b, 1'b1);
    bus.stop = 1'b1;
    go(1);
    bus.stop = 1'b0;
    check("stop_pb_c14", bus.phase_b, 1'b0);
    check("stop_busy_c14", bus.busy, 1'b1);
    go_to(15); check("stop_busy_c15", bus.busy, 1'b1);
    check("stop_done_c15", bus.done, 1'b0);
    go_to(16); check("stop_done_c16", bus.done, 1'b1);
    check("stop_busy_c16", bus.busy, 1'b0);
    check("stop_cnt_c16", bus.cycle_cnt, 16'd0);
    go(2);

    // Config error
    launch(5, 5, 0);
    check("cfg_err_c1", bus.cfg_err, 1'b1);
    check("cfg_busy_c1", bus.busy, 1'b0);
    check("cfg_pa_c1", bus.phase_a, 1'b0);
    go(1); check("cfg_err_c2", bus.cfg_err, 1'b0);

    // start and stop together in IDLE
    bus.half_period = 16'd10; bus.dead_time = 16'd2; bus.burst_len = 16'd0;
    bus.start = 1'b1; bus.stop = 1'b1;
    go(1);
    bus.start = 1'b0; bus.stop = 1'b0;
    check("both_busy", bus.busy, 1'b0);
    check("both_cfg_err", bus.cfg_err, 1'b0);
    check("both_done", bus.done, 1'b0);
    go(1);

    // Zero dead time: hp=4 dt=0 bl=2
    launch(4, 0, 2);
    check("zdt_pa_c1", bus.phase_a, 1'b1);
    go_to(4);  check("zdt_pa_c4", bus.phase_a, 1'b1);
    go_to(5);  check("zdt_pb_c5", bus.phase_b, 1'b1);
    check("zdt_pa_c5", bus.phase_a, 1'b0);
    go_to(8);  check("zdt_pb_c8", bus.phase_b, 1'b1);
    go_to(9);  check("zdt_pa_c9", bus.phase_a, 1'b1);
    check("zdt_cnt_c9", bus.cycle_cnt, 16'd1);
    go_to(16); check("zdt_pb_c16", bus.phase_b, 1'b1);
    go_to(17); check("zdt_done_c17", bus.done, 1'b1);
    check("zdt_busy_c17", bus.busy, 1'b0);
    check("zdt_cnt_c17", bus.cycle_cnt, 16'd2);
    go(1);

    // Reset mid-PH_A, then a clean restart with new config
    launch(10, 2, 0);
    go_to(5);
    rst_n = 1'b0;
    go(1);
    check("rst_mid_pa", bus.phase_a, 1'b0);
    check("rst_mid_pb", bus.phase_b, 1'b0);
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_done", bus.done, 1'b0);
    check("rst_mid_cnt", bus.cycle_cnt, 16'd0);
    rst_n = 1'b1;
    go(1);
    launch(6, 1, 1);
    check("rerun_pa_c1", bus.phase_a, 1'b1);
    go_to(13); check("rerun_done_c13", bus.done, 1'b1);
    check("rerun_cnt_c13", bus.cycle_cnt, 16'd1);
    go(1);

    // Default config, continuous: one full 48000-cycle period
    launch(24000, 100, 0);
    go_to(23900); check("dflt_pa_c23900", bus.phase_a, 1'b1);
    go_to(23901); check("dflt_pa_c23901", bus.phase_a, 1'b0);
    go_to(24001); check("dflt_pb_c24001", bus.phase_b, 1'b1);
    go_to(47900); check("dflt_pb_c47900", bus.phase_b, 1'b1);
    go_to(47901); check("dflt_pb_c47901", bus.phase_b, 1'b0);
    go_to(48000); check("dflt_cnt_c48000", bus.cycle_cnt, 16'd0);
    go_to(48001); check("dflt_pa_c48001", bus.phase_a, 1'b1);
    check("dflt_cnt_c48001", bus.cycle_cnt, 16'd1);
    bus.stop = 1'b1;
    go(1);
    bus.stop = 1'b0;
    wait_idle();

    // Randomized phase: random config, start/stop pulses and occasional reset
    for (int i = 0; i < 3000; i++) begin
      bus.half_period = 16'($urandom_range(1, 10));
      bus.dead_time   = 16'($urandom_range(0, 6));
      bus.burst_len   = 16'($urandom_range(0, 3));
      bus.start       = ($urandom_range(0, 5) == 0);
      bus.stop        = ($urandom_range(0, 24) == 0);
      rst_n           = ($urandom_range(0, 399) != 0);
      go(1);
    end
    bus.start = 1'b0; bus.stop = 1'b0; rst_n = 1'b1;
    go(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
